// File: rtl/dsp_pkg.sv
// Shared constants for the DSP block family: depth/width limits, occupancy
// width and the reset-style selector used by registered primitives.
package dsp_pkg;

    localparam int unsigned MAX_DEPTH = 8;
    localparam int unsigned MAX_WIDTH = 48;
    localparam int unsigned OCC_W     = 4;

    localparam bit RST_SYNC  = 1'b0;
    localparam bit RST_ASYNC = 1'b1;

endpackage

// File: rtl/dsp_pipe_delay_if.sv
// Data/valid stream in and out of the delay pipe, plus its occupancy report.
interface dsp_pipe_delay_if #(
    parameter int unsigned WIDTH = 18
);
    import dsp_pkg::*;

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output in_data,
        output in_valid,
        input  out_data,
        input  out_valid,
        input  occupancy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output out_data,
        output out_valid,
        output occupancy
    );

endinterface

// File: rtl/dsp_pipe_stage.sv
// One pipe stage: data register plus valid bit with clock enable and
// valid-only flush. Reset style is selectable so other DSP blocks can reuse it.
module dsp_pipe_stage
    import dsp_pkg::*;
#(
    parameter int unsigned WIDTH    = 18,
    parameter bit          RST_MODE = RST_ASYNC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_valid_nxt;

    // Flush only drops the valid bit; data keeps its last loaded value.
    always_comb begin
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        if (flush) begin
            w_valid_nxt = 1'b0;
        end else if (ce) begin
            w_data_nxt  = i_data;
            w_valid_nxt = i_valid;
        end
    end

    if (RST_MODE == RST_ASYNC) begin : g_async
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_data  <= w_data_nxt;
                r_valid <= w_valid_nxt;
            end
        end
    end else begin : g_sync
        always_ff @(posedge clk) begin
            if (rst) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_data  <= w_data_nxt;
                r_valid <= w_valid_nxt;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/dsp_pipe_delay.sv
// Fixed-latency data/valid delay line of DEPTH stages with shared clock
// enable, flush and occupancy count; DEPTH=0 degenerates to a wire.
module dsp_pipe_delay
    import dsp_pkg::*;
#(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic           flush,
    dsp_pipe_delay_if.slave bus
);

    if (DEPTH > MAX_DEPTH || WIDTH == 0 || WIDTH > MAX_WIDTH) begin : g_param_err
        $error("dsp_pipe_delay: WIDTH=%0d DEPTH=%0d out of range", WIDTH, DEPTH);
    end

    if (DEPTH == 0) begin : g_bypass
        logic w_unused;
        assign w_unused      = &{1'b0, clk, rst, ce, flush};
        assign bus.out_data  = bus.in_data;
        assign bus.out_valid = bus.in_valid;
        assign bus.occupancy = '0;
    end else begin : g_pipe
        logic [WIDTH-1:0] w_data [DEPTH+1];
        logic [DEPTH:0]   w_valid;
        logic [OCC_W-1:0] w_occ;

        assign w_data[0]  = bus.in_data;
        assign w_valid[0] = bus.in_valid;

        for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
            dsp_pipe_stage #(
                .WIDTH    (WIDTH),
                .RST_MODE (RST_ASYNC)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .ce      (ce),
                .flush   (flush),
                .i_data  (w_data[k]),
                .i_valid (w_valid[k]),
                .o_data  (w_data[k+1]),
                .o_valid (w_valid[k+1])
            );
        end

        // Population count of the stage valid bits (index 0 is the input, not a stage).
        always_comb begin
            w_occ = '0;
            for (int k = 1; k <= int'(DEPTH); k++) begin
                w_occ = w_occ + OCC_W'(w_valid[k]);
            end
        end

        assign bus.out_data  = w_data[DEPTH];
        assign bus.out_valid = w_valid[DEPTH];
        assign bus.occupancy = w_occ;
    end

endmodule

// File: tb/tb_dsp_pipe_delay.sv
// Bench for dsp_pipe_delay at DEPTH 0, 3 and 8, checked every cycle against
// a queue model of in-flight items plus directed literal expectations.
module tb_dsp_pipe_delay;
    import dsp_pkg::*;

    localparam int unsigned W = 18;

    typedef struct packed {
        logic [W-1:0] d;
        logic         v;
    } item_t;
    typedef item_t iq_t[$];

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         ce       = 1'b0;
    logic         flush    = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic         in_valid = 1'b0;

    int checks   = 0;
    int failures = 0;

    iq_t q3;
    iq_t q8;

    always #5 clk = ~clk;

    dsp_pipe_delay_if #(.WIDTH(W)) bus0 ();
    dsp_pipe_delay_if #(.WIDTH(W)) bus3 ();
    dsp_pipe_delay_if #(.WIDTH(W)) bus8 ();

    assign bus0.in_data = in_data;  assign bus0.in_valid = in_valid;
    assign bus3.in_data = in_data;  assign bus3.in_valid = in_valid;
    assign bus8.in_data = in_data;  assign bus8.in_valid = in_valid;

    dsp_pipe_delay #(.WIDTH(W), .DEPTH(0)) u_d0 (.clk(clk), .rst(rst), .ce(ce), .flush(flush), .bus(bus0));
    dsp_pipe_delay #(.WIDTH(W), .DEPTH(3)) u_d3 (.clk(clk), .rst(rst), .ce(ce), .flush(flush), .bus(bus3));
    dsp_pipe_delay #(.WIDTH(W), .DEPTH(8)) u_d8 (.clk(clk), .rst(rst), .ce(ce), .flush(flush), .bus(bus8));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: queue of in-flight items, front is the oldest (the one at the output).
    function automatic iq_t q_zero(input int n);
        iq_t r;
        repeat (n) r.push_back('0);
        return r;
    endfunction

    function automatic iq_t q_shift(input iq_t q, input item_t it);
        iq_t r = q;
        r.push_back(it);
        void'(r.pop_front());
        return r;
    endfunction

    function automatic iq_t q_kill(input iq_t q);
        iq_t r = q;
        foreach (r[k]) r[k].v = 1'b0;
        return r;
    endfunction

    function automatic int q_occ(input iq_t q);
        int n = 0;
        foreach (q[k]) n += int'(q[k].v);
        return n;
    endfunction

    task automatic model_reset();
        q3 = q_zero(3);
        q8 = q_zero(8);
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (flush) begin
            q3 = q_kill(q3);
            q8 = q_kill(q8);
        end else if (ce) begin
            q3 = q_shift(q3, item_t'{d: in_data, v: in_valid});
            q8 = q_shift(q8, item_t'{d: in_data, v: in_valid});
        end
    endtask

    // Apply one cycle of inputs, advance the model at the edge, return mid-cycle.
    task automatic cyc(input logic [W-1:0] d, input logic v, input logic c, input logic f);
        in_data  = d;
        in_valid = v;
        ce       = c;
        flush    = f;
        @(posedge clk);
        model_edge();
        #4;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_d3_data",  64'(bus3.out_data),  64'd0);
        chk("rst_d3_valid", 64'(bus3.out_valid), 64'd0);
        chk("rst_d3_occ",   64'(bus3.occupancy), 64'd0);
        chk("rst_d8_occ",   64'(bus8.occupancy), 64'd0);
        #1;
        rst = 1'b0;
    endtask

    // Every-cycle comparison against the model, between edges.
    always @(posedge clk) begin
        #3;
        chk("d0_data",  64'(bus0.out_data),  64'(in_data));
        chk("d0_valid", 64'(bus0.out_valid), 64'(in_valid));
        chk("d0_occ",   64'(bus0.occupancy), 64'd0);
        chk("d3_data",  64'(bus3.out_data),  64'(q3[0].d));
        chk("d3_valid", 64'(bus3.out_valid), 64'(q3[0].v));
        chk("d3_occ",   64'(bus3.occupancy), 64'(q_occ(q3)));
        chk("d8_data",  64'(bus8.out_data),  64'(q8[0].d));
        chk("d8_valid", 64'(bus8.out_valid), 64'(q8[0].v));
        chk("d8_occ",   64'(bus8.occupancy), 64'(q_occ(q8)));
    end

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (2) cyc(18'h3FFFF, 1'b1, 1'b1, 1'b0);
        chk("reset_d3_data",  64'(bus3.out_data),  64'd0);
        chk("reset_d3_valid", 64'(bus3.out_valid), 64'd0);
        chk("reset_d8_occ",   64'(bus8.occupancy), 64'd0);
        rst = 1'b0;

        // Single item latency through three stages.
        cyc(18'h00001, 1'b1, 1'b1, 1'b0);
        chk("lat_e1_valid", 64'(bus3.out_valid), 64'd0);
        cyc(18'h00000, 1'b0, 1'b1, 1'b0);
        chk("lat_e2_valid", 64'(bus3.out_valid), 64'd0);
        cyc(18'h00000, 1'b0, 1'b1, 1'b0);
        chk("lat_e3_data",  64'(bus3.out_data),  64'h1);
        chk("lat_e3_valid", 64'(bus3.out_valid), 64'd1);
        cyc(18'h00000, 1'b0, 1'b1, 1'b0);
        chk("lat_e4_valid", 64'(bus3.out_valid), 64'd0);

        // A,B,C then two stalled cycles.
        cyc(18'h0AAAA, 1'b1, 1'b1, 1'b0);
        cyc(18'h15555, 1'b1, 1'b1, 1'b0);
        cyc(18'h3C3C3, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(18'h01234, 1'b1, 1'b0, 1'b0);
            chk("stall_data", 64'(bus3.out_data),  64'h0AAAA);
            chk("stall_occ",  64'(bus3.occupancy), 64'd3);
        end
        cyc(18'h00000, 1'b0, 1'b1, 1'b0);
        chk("stall_b_data", 64'(bus3.out_data), 64'h15555);
        cyc(18'h00000, 1'b0, 1'b1, 1'b0);
        chk("stall_c_data",  64'(bus3.out_data),  64'h3C3C3);
        chk("stall_c_valid", 64'(bus3.out_valid), 64'd1);

        // Flush of a full pipe with ce low and a valid input.
        cyc(18'h00011, 1'b1, 1'b1, 1'b0);
        cyc(18'h00022, 1'b1, 1'b1, 1'b0);
        cyc(18'h00033, 1'b1, 1'b1, 1'b0);
        chk("full_occ", 64'(bus3.occupancy), 64'd3);
        cyc(18'h2FFFF, 1'b1, 1'b0, 1'b1);
        chk("flush_valid", 64'(bus3.out_valid), 64'd0);
        chk("flush_occ",   64'(bus3.occupancy), 64'd0);
        chk("flush_data",  64'(bus3.out_data),  64'h00011);
        cyc(18'h2EEEE, 1'b1, 1'b1, 1'b1);
        chk("flush_ce_data", 64'(bus3.out_data), 64'h00011);

        // Async reset between edges with two items in flight.
        cyc(18'h00E01, 1'b1, 1'b1, 1'b0);
        cyc(18'h00E02, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_occ", 64'(bus3.occupancy), 64'd2);
        rst_pulse();
        for (int i = 0; i < 3; i++) begin
            cyc(18'h00000, 1'b0, 1'b1, 1'b0);
            chk("post_rst_valid", 64'(bus3.out_valid), 64'd0);
        end

        // Bypass ignores ce and flush.
        in_data = 18'h3FFFF; in_valid = 1'b1; ce = 1'b0; flush = 1'b1;
        #1;
        chk("byp_data",  64'(bus0.out_data),  64'h3FFFF);
        chk("byp_valid", 64'(bus0.out_valid), 64'd1);
        chk("byp_occ",   64'(bus0.occupancy), 64'd0);
        cyc(18'h3FFFF, 1'b1, 1'b0, 1'b1);

        // Alternating valid into the 8-deep pipe.
        for (int i = 0; i < 20; i++) begin
            cyc(W'($urandom), (i % 2) == 0, 1'b1, 1'b0);
            if (i >= 7) chk("alt_d8_occ", 64'(bus8.occupancy), 64'd4);
        end

        // Random traffic with stalls, flushes and occasional async resets.
        for (int i = 0; i < 600; i++) begin
            cyc(W'($urandom), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 59) == 0) rst_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp_pipe_delay.md
DSP_PIPE_DELAY -- requirements
Module: dsp_pipe_delay

Interface
REQ-001 Parameter WIDTH, default 18, data width in bits (1..48).
REQ-002 Parameter DEPTH, default 2, number of register stages (0..MAX_DEPTH); 0 = pure combinational bypass.
REQ-003 Port clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port ce  input  1  clock enable for all stages; 0 = whole pipe holds.
REQ-006 Port flush  input  1  synchronous invalidate of all in-flight items.
REQ-007 Port in_data  input  WIDTH  data entering stage 0.
REQ-008 Port in_valid  input  1  qualifies in_data.
REQ-009 Port out_data  output  WIDTH  data leaving last stage.
REQ-010 Port out_valid  output  1  qualifies out_data.
REQ-011 Port occupancy  output  OCC_W  count of valid items currently held in the stages.

Function
REQ-012 Each stage k SHALL hold a data register and a valid bit; stage 0 loads in_data/in_valid, stage k loads stage k-1.
REQ-013 On a rising edge with ce=1 and flush=0, all stages SHALL shift by one simultaneously.
REQ-014 On a rising edge with ce=0 and flush=0, all data and valid bits SHALL hold.
REQ-015 out_data/out_valid SHALL be driven directly from stage DEPTH-1 (no output logic beyond the register).
REQ-016 Latency in_data -> out_data SHALL be exactly DEPTH rising edges with ce=1; cycles with ce=0 do not count.
REQ-017 On a rising edge with flush=1, all valid bits SHALL clear regardless of ce; in_valid of that cycle is discarded.
REQ-018 flush SHALL NOT modify data registers; only valid bits clear.
REQ-019 Data registers SHALL load on ce=1 even when in_valid=0 (valid bit alone marks bubbles).
REQ-020 occupancy SHALL equal the combinational population count of the DEPTH valid bits, range 0..DEPTH.
REQ-021 With DEPTH=0: out_data=in_data, out_valid=in_valid combinationally, occupancy=0, ce and flush ignored, no registers inferred.
REQ-022 DEPTH > MAX_DEPTH or WIDTH < 1 SHALL fail elaboration.
REQ-023 Full pipe (occupancy=DEPTH) with ce=1 and in_valid=1 SHALL keep occupancy=DEPTH (one enters, one exits same edge).

Reset
REQ-024 rst=1 SHALL asynchronously clear all data registers and valid bits to 0, independent of clk and ce.
REQ-025 During and after reset out_data=0, out_valid=0, occupancy=0 until the first shifting edge.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight items; no item emerges after deassertion.
REQ-027 rst SHALL take priority over flush and ce.

Structure
REQ-028 Shared package dsp_pkg SHALL hold MAX_DEPTH (=8), OCC_W (=4) and the RST_SYNC/RST_ASYNC mode constants used across DSP blocks.
REQ-029 One sub-module dsp_pipe_stage (data + valid register, ce, flush, async rst) SHALL be instantiated DEPTH times via generate.
REQ-030 Occupancy popcount SHALL live in the top level, not in the stage.

Verification
REQ-031 WIDTH=18, DEPTH=3, ce=1: in_data=0x00001 valid at cycle 0 -> out_data=0x00001, out_valid=1 at cycle 3 only.
REQ-032 DEPTH=3: items A,B,C on cycles 0-2, ce=0 on cycles 3-4 -> outputs frozen, C emerges cycle 7, occupancy 3 held during stall.
REQ-033 DEPTH=3 full, flush=1 with ce=0 and in_valid=1 -> next edge out_valid=0, occupancy=0, out_data unchanged.
REQ-034 DEPTH=3, rst pulsed between clock edges with occupancy=2 -> out_data=0, out_valid=0, occupancy=0 immediately, nothing emerges for 3 cycles after release.
REQ-035 DEPTH=0: in_data=0x3FFFF, in_valid=1, ce=0, flush=1 -> out_data=0x3FFFF, out_valid=1 same cycle, occupancy=0.
REQ-036 DEPTH=8 alternating in_valid 1/0 with ce=1 -> out_valid pattern equals input pattern delayed 8, occupancy steady at 4.
